// File: rtl/rpn_exec.sv
// rpn_exec: command sequencer and arithmetic unit driving the RPN operand stack from the initiator side.
// Define RPN_EXEC_DIV_EN to turn cmd_op 111 into unsigned DIV; otherwise 111 completes as a no-op.
module rpn_exec #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  stk_push,
    output logic                  stk_pop,
    output logic [DATA_WIDTH-1:0] stk_wdata,
    input  logic [DATA_WIDTH-1:0] stk_rdata,
    output logic                  stk_reset,
    output logic                  done,
    output logic [1:0]            err,
    output logic [DATA_WIDTH-1:0] top,
    output logic [ADDR_WIDTH:0]   depth
);

    localparam int unsigned CNT_W    = ADDR_WIDTH + 1;
    localparam int unsigned CAPACITY = 1 << ADDR_WIDTH;

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_DUP   = 3'b100;
    localparam logic [2:0] OP_DROP  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_DIV   = 3'b111;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_UNDER = 2'b01;
    localparam logic [1:0] ERR_OVER  = 2'b10;
    localparam logic [1:0] ERR_DIVZ  = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        PUSH_L,
        POP_B,
        POP_A,
        LATCH_A,
        PUSH_R,
        DUP_W,
        CLR,
        ERR
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [2:0]            op_q;
    logic [2:0]            op_nxt;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] b_nxt;

    logic                  cmd_ready_nxt;
    logic                  push_nxt;
    logic                  pop_nxt;
    logic                  clr_nxt;
    logic                  done_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt;
    logic [DATA_WIDTH-1:0] top_nxt;
    logic [1:0]            err_nxt;
    logic [CNT_W-1:0]      depth_nxt;

    logic                  full;
    logic                  empty;
    logic                  lt_two;
    logic                  div_op;
    logic                  binary_op;
    logic [DATA_WIDTH-1:0] result;
    logic [1:0]            result_err;

    // Shadow copy of the stack contents so the top mirror survives pops.
    logic [DATA_WIDTH-1:0] shadow [CAPACITY];
    logic                  sh_we;
    logic [ADDR_WIDTH-1:0] sh_addr;
    logic [DATA_WIDTH-1:0] sh_data;
    logic [DATA_WIDTH-1:0] below_top;

    assign full      = (depth == CNT_W'(CAPACITY));
    assign empty     = (depth == '0);
    assign lt_two    = (depth < CNT_W'(2));
    assign below_top = (depth <= CNT_W'(1)) ? '0 : shadow[ADDR_WIDTH'(depth - CNT_W'(2))];

`ifdef RPN_EXEC_DIV_EN
    assign div_op = (cmd_op == OP_DIV);
`else
    assign div_op = 1'b0;
`endif

    assign binary_op = (cmd_op == OP_ADD) || (cmd_op == OP_SUB) || (cmd_op == OP_MUL) || div_op;

    // Arithmetic on A (arriving on stk_rdata in LATCH_A) and latched B.
    always_comb begin
        result     = '0;
        result_err = ERR_OK;
        case (op_q)
            OP_ADD:  result = stk_rdata + b_q;
            OP_SUB:  result = stk_rdata - b_q;
            OP_MUL:  result = DATA_WIDTH'(stk_rdata * b_q);
`ifdef RPN_EXEC_DIV_EN
            OP_DIV: begin
                if (b_q == '0) begin
                    result     = '1;
                    result_err = ERR_DIVZ;
                end else begin
                    result = stk_rdata / b_q;
                end
            end
`endif
            default: result = '0;
        endcase
    end

    // Next state and next values of every registered output.
    always_comb begin
        state_nxt     = state;
        op_nxt        = op_q;
        b_nxt         = b_q;
        cmd_ready_nxt = 1'b0;
        push_nxt      = 1'b0;
        pop_nxt       = 1'b0;
        clr_nxt       = 1'b0;
        done_nxt      = 1'b0;
        wdata_nxt     = stk_wdata;
        top_nxt       = top;
        err_nxt       = err;
        depth_nxt     = depth;
        sh_we         = 1'b0;
        sh_addr       = '0;
        sh_data       = '0;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_nxt = cmd_op;
                    if (binary_op) begin
                        if (lt_two) begin
                            state_nxt = ERR;
                            done_nxt  = 1'b1;
                            err_nxt   = ERR_UNDER;
                        end else begin
                            state_nxt = POP_B;
                            pop_nxt   = 1'b1;
                        end
                    end else begin
                        case (cmd_op)
                            OP_PUSH: begin
                                done_nxt = 1'b1;
                                if (full) begin
                                    state_nxt = ERR;
                                    err_nxt   = ERR_OVER;
                                end else begin
                                    state_nxt = PUSH_L;
                                    push_nxt  = 1'b1;
                                    wdata_nxt = cmd_data;
                                    err_nxt   = ERR_OK;
                                    depth_nxt = depth + CNT_W'(1);
                                    top_nxt   = cmd_data;
                                    sh_we     = 1'b1;
                                    sh_addr   = ADDR_WIDTH'(depth);
                                    sh_data   = cmd_data;
                                end
                            end
                            OP_DUP: begin
                                done_nxt = 1'b1;
                                if (empty) begin
                                    state_nxt = ERR;
                                    err_nxt   = ERR_UNDER;
                                end else if (full) begin
                                    state_nxt = ERR;
                                    err_nxt   = ERR_OVER;
                                end else begin
                                    state_nxt = DUP_W;
                                    push_nxt  = 1'b1;
                                    wdata_nxt = top;
                                    err_nxt   = ERR_OK;
                                    depth_nxt = depth + CNT_W'(1);
                                    sh_we     = 1'b1;
                                    sh_addr   = ADDR_WIDTH'(depth);
                                    sh_data   = top;
                                end
                            end
                            OP_DROP: begin
                                if (empty) begin
                                    state_nxt = ERR;
                                    done_nxt  = 1'b1;
                                    err_nxt   = ERR_UNDER;
                                end else begin
                                    state_nxt = POP_B;
                                    pop_nxt   = 1'b1;
                                end
                            end
                            OP_CLEAR: begin
                                state_nxt = CLR;
                                clr_nxt   = 1'b1;
                                done_nxt  = 1'b1;
                                err_nxt   = ERR_OK;
                                depth_nxt = '0;
                                top_nxt   = '0;
                            end
                            default: begin
                                // Unused opcode: complete cleanly without touching the stack.
                                state_nxt = ERR;
                                done_nxt  = 1'b1;
                                err_nxt   = ERR_OK;
                            end
                        endcase
                    end
                end
            end
            POP_B: begin
                if (op_q == OP_DROP) begin
                    state_nxt = LATCH_A;
                    done_nxt  = 1'b1;
                    err_nxt   = ERR_OK;
                    depth_nxt = depth - CNT_W'(1);
                    top_nxt   = below_top;
                end else begin
                    state_nxt = POP_A;
                    pop_nxt   = 1'b1;
                end
            end
            POP_A: begin
                state_nxt = LATCH_A;
                b_nxt     = stk_rdata;
            end
            LATCH_A: begin
                if (op_q == OP_DROP) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = PUSH_R;
                    push_nxt  = 1'b1;
                    wdata_nxt = result;
                    done_nxt  = 1'b1;
                    err_nxt   = result_err;
                    depth_nxt = depth - CNT_W'(1);
                    top_nxt   = result;
                    sh_we     = 1'b1;
                    sh_addr   = ADDR_WIDTH'(depth - CNT_W'(2));
                    sh_data   = result;
                end
            end
            PUSH_L, PUSH_R, DUP_W, CLR, ERR: state_nxt = IDLE;
            default:                         state_nxt = IDLE;
        endcase

        cmd_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_PUSH;
            b_q       <= '0;
            cmd_ready <= 1'b1;
            stk_push  <= 1'b0;
            stk_pop   <= 1'b0;
            stk_reset <= 1'b0;
            done      <= 1'b0;
            stk_wdata <= '0;
            top       <= '0;
            err       <= ERR_OK;
            depth     <= '0;
        end else begin
            state     <= state_nxt;
            op_q      <= op_nxt;
            b_q       <= b_nxt;
            cmd_ready <= cmd_ready_nxt;
            stk_push  <= push_nxt;
            stk_pop   <= pop_nxt;
            stk_reset <= clr_nxt;
            done      <= done_nxt;
            stk_wdata <= wdata_nxt;
            top       <= top_nxt;
            err       <= err_nxt;
            depth     <= depth_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (sh_we && !reset) begin
            shadow[sh_addr] <= sh_data;
        end
    end

endmodule

// File: tb/tb_rpn_exec.sv
// tb_rpn_exec: directed vectors for rpn_exec against a behavioural stack; honours RPN_EXEC_DIV_EN.
module tb_rpn_exec;

    localparam int unsigned DW = 4;
    localparam int unsigned AW = 6;

    localparam logic [2:0] OP_PUSH  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_MUL   = 3'b011;
    localparam logic [2:0] OP_DUP   = 3'b100;
    localparam logic [2:0] OP_DROP  = 3'b101;
    localparam logic [2:0] OP_CLEAR = 3'b110;
    localparam logic [2:0] OP_111   = 3'b111;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          stk_push;
    logic          stk_pop;
    logic [DW-1:0] stk_wdata;
    logic [DW-1:0] stk_rdata;
    logic          stk_reset;
    logic          done;
    logic [1:0]    err;
    logic [DW-1:0] top;
    logic [AW:0]   depth;

    int vectors     = 0;
    int miscompares = 0;

    int unsigned done_at, done_cnt, ready_at, push_at, pop_mask;
    int unsigned push_cnt, pop_cnt, rst_cnt, wdata_seen, err_seen;
    int unsigned clash = 0;

    // Behavioural operand stack: rdata is registered, valid the cycle after a pop.
    logic [DW-1:0] smem [1 << AW];
    int            sp = 0;
    logic [DW-1:0] srd = '0;

    assign stk_rdata = srd;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset || stk_reset) begin
            sp <= 0;
        end else if (stk_push) begin
            smem[sp] <= stk_wdata;
            sp       <= sp + 1;
        end else if (stk_pop) begin
            srd <= smem[sp - 1];
            sp  <= sp - 1;
        end
    end

    rpn_exec #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .stk_push  (stk_push),
        .stk_pop   (stk_pop),
        .stk_wdata (stk_wdata),
        .stk_rdata (stk_rdata),
        .stk_reset (stk_reset),
        .done      (done),
        .err       (err),
        .top       (top),
        .depth     (depth)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command at a negedge and record what happens over the next six cycles.
    task automatic run_cmd(input logic [2:0] op, input logic [DW-1:0] data);
        int unsigned guard = 0;
        while (!cmd_ready && guard < 16) begin
            @(negedge clk);
            guard++;
        end
        check("cmd_ready_wait", 32'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_data   = data;
        done_at    = 0;
        done_cnt   = 0;
        ready_at   = 0;
        push_at    = 0;
        pop_mask   = 0;
        push_cnt   = 0;
        pop_cnt    = 0;
        rst_cnt    = 0;
        wdata_seen = 0;
        err_seen   = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (done) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at  = k;
                    err_seen = 32'(err);
                end
            end
            if (cmd_ready && ready_at == 0) ready_at = k;
            if (stk_push) begin
                push_cnt++;
                push_at    = k;
                wdata_seen = 32'(stk_wdata);
            end
            if (stk_pop) begin
                pop_cnt++;
                pop_mask = pop_mask | (32'd1 << k);
            end
            if (stk_reset) rst_cnt++;
            if (32'(stk_push) + 32'(stk_pop) + 32'(stk_reset) > 1) clash++;
        end
    endtask

    task automatic chk_cmd(input string tag, input int unsigned exp_done_at, input int unsigned exp_err,
                           input int unsigned exp_depth, input int unsigned exp_top);
        check({tag, ".done_at"}, done_at, exp_done_at);
        check({tag, ".done_cnt"}, done_cnt, 1);
        check({tag, ".err"}, err_seen, exp_err);
        check({tag, ".depth"}, 32'(depth), exp_depth);
        check({tag, ".top"}, 32'(top), exp_top);
    endtask

    initial begin
        cmd_valid = 1'b0;
        cmd_op    = OP_PUSH;
        cmd_data  = '0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst.cmd_ready", 32'(cmd_ready), 1);
        check("rst.done", 32'(done), 0);
        check("rst.err", 32'(err), 0);
        check("rst.top", 32'(top), 0);
        check("rst.depth", 32'(depth), 0);
        check("rst.strobes", 32'(stk_push) + 32'(stk_pop) + 32'(stk_reset), 0);
        check("rst.wdata", 32'(stk_wdata), 0);

        // 3 + 5
        run_cmd(OP_PUSH, 4'd3);
        chk_cmd("push3", 1, 0, 1, 3);
        check("push3.wdata", wdata_seen, 3);
        check("push3.ready_at", ready_at, 2);
        run_cmd(OP_PUSH, 4'd5);
        chk_cmd("push5", 1, 0, 2, 5);
        run_cmd(OP_ADD, 4'd0);
        chk_cmd("add", 4, 0, 1, 8);
        check("add.wdata", wdata_seen, 8);
        check("add.push_at", push_at, 4);
        check("add.push_cnt", push_cnt, 1);
        check("add.pop_mask", pop_mask, 32'h6);
        check("add.ready_at", ready_at, 5);

        run_cmd(OP_DROP, 4'd0);
        chk_cmd("drop_last", 2, 0, 0, 0);
        check("drop_last.pop_mask", pop_mask, 32'h2);

        // 2 - 7 wraps to 0xB, then MUL underflows with one entry
        run_cmd(OP_PUSH, 4'd2);
        run_cmd(OP_PUSH, 4'd7);
        run_cmd(OP_SUB, 4'd0);
        chk_cmd("sub_wrap", 4, 0, 1, 11);
        check("sub_wrap.wdata", wdata_seen, 11);
        run_cmd(OP_MUL, 4'd0);
        chk_cmd("mul_uf", 1, 1, 1, 11);
        check("mul_uf.pop_cnt", pop_cnt, 0);
        check("mul_uf.push_cnt", push_cnt, 0);
        check("mul_uf.ready_at", ready_at, 2);

        run_cmd(OP_CLEAR, 4'd0);
        chk_cmd("clr1", 1, 0, 0, 0);
        check("clr1.rst_cnt", rst_cnt, 1);

        // Fill to capacity with literals i mod 16
        for (int i = 0; i < 64; i++) run_cmd(OP_PUSH, DW'(i));
        check("fill.depth", 32'(depth), 64);
        check("fill.top", 32'(top), 15);
        run_cmd(OP_PUSH, 4'd1);
        chk_cmd("push_ovf", 1, 2, 64, 15);
        check("push_ovf.push_cnt", push_cnt, 0);
        run_cmd(OP_DUP, 4'd0);
        chk_cmd("dup_ovf", 1, 2, 64, 15);
        check("dup_ovf.push_cnt", push_cnt, 0);
        run_cmd(OP_ADD, 4'd0);
        chk_cmd("add_full", 4, 0, 63, 13);
        run_cmd(OP_CLEAR, 4'd0);

        // 9 DUP ADD -> 18 mod 16
        run_cmd(OP_PUSH, 4'd9);
        run_cmd(OP_DUP, 4'd0);
        chk_cmd("dup", 1, 0, 2, 9);
        check("dup.wdata", wdata_seen, 9);
        run_cmd(OP_ADD, 4'd0);
        chk_cmd("add_wrap", 4, 0, 1, 2);
        run_cmd(OP_DROP, 4'd0);
        chk_cmd("drop_to_empty", 2, 0, 0, 0);
        run_cmd(OP_DROP, 4'd0);
        chk_cmd("drop_uf", 1, 1, 0, 0);
        check("drop_uf.pop_cnt", pop_cnt, 0);

        // Top mirror after successive drops
        run_cmd(OP_PUSH, 4'd1);
        run_cmd(OP_PUSH, 4'd2);
        run_cmd(OP_PUSH, 4'd3);
        run_cmd(OP_DROP, 4'd0);
        chk_cmd("drop_a", 2, 0, 2, 2);
        run_cmd(OP_DROP, 4'd0);
        chk_cmd("drop_b", 2, 0, 1, 1);
        run_cmd(OP_CLEAR, 4'd0);

        run_cmd(OP_PUSH, 4'd6);
        run_cmd(OP_PUSH, 4'd7);
        run_cmd(OP_MUL, 4'd0);
        chk_cmd("mul", 4, 0, 1, 10);
        check("mul.wdata", wdata_seen, 10);

        run_cmd(OP_CLEAR, 4'd0);
        run_cmd(OP_PUSH, 4'd4);
        run_cmd(OP_PUSH, 4'd6);
        run_cmd(OP_CLEAR, 4'd0);
        chk_cmd("clear", 1, 0, 0, 0);
        check("clear.rst_cnt", rst_cnt, 1);
        check("clear.push_pop", push_cnt + pop_cnt, 0);

`ifdef RPN_EXEC_DIV_EN
        run_cmd(OP_PUSH, 4'd13);
        run_cmd(OP_PUSH, 4'd4);
        run_cmd(OP_111, 4'd0);
        chk_cmd("div", 4, 0, 1, 3);
        check("div.wdata", wdata_seen, 3);
        run_cmd(OP_PUSH, 4'd5);
        run_cmd(OP_PUSH, 4'd0);
        run_cmd(OP_111, 4'd0);
        chk_cmd("div0", 4, 3, 2, 15);
        check("div0.wdata", wdata_seen, 15);
`else
        run_cmd(OP_PUSH, 4'd13);
        run_cmd(OP_PUSH, 4'd4);
        run_cmd(OP_111, 4'd0);
        chk_cmd("op7_nop", 1, 0, 2, 4);
        check("op7_nop.strobes", push_cnt + pop_cnt + rst_cnt, 0);
`endif

        // Reset two cycles into a binary op
        run_cmd(OP_CLEAR, 4'd0);
        run_cmd(OP_PUSH, 4'd1);
        run_cmd(OP_PUSH, 4'd2);
        cmd_valid = 1'b1;
        cmd_op    = OP_ADD;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("midrst.pop_t1", 32'(stk_pop), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst.strobes", 32'(stk_push) + 32'(stk_pop) + 32'(stk_reset), 0);
        check("midrst.done", 32'(done), 0);
        check("midrst.ready", 32'(cmd_ready), 1);
        check("midrst.depth", 32'(depth), 0);
        check("midrst.top", 32'(top), 0);
        run_cmd(OP_PUSH, 4'd5);
        chk_cmd("post_rst_push", 1, 0, 1, 5);

        check("strobe_clash", clash, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
